// File: rtl/mc14500_sequencer_if.sv
// Program-memory and ICU bus between the mc14500 sequencer (master) and its
// program ROM / ICU (slave).
interface mc14500_sequencer_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned ADDR_W = 8
) ();
  logic                rom_req;
  logic [PC_W-1:0]     rom_addr;
  logic                rom_ack;
  logic [4+ADDR_W-1:0] rom_data;
  logic                icu_rst;
  logic [3:0]          icu_i;
  logic                icu_jmp;
  logic                icu_rtn;
  logic                icu_flag_f;
  logic                icu_rr;
  logic [ADDR_W-1:0]   io_addr;
  logic                io_valid;

  modport master (
    output rom_req, rom_addr, icu_rst, icu_i, io_addr, io_valid,
    input  rom_ack, rom_data, icu_jmp, icu_rtn, icu_flag_f, icu_rr
  );

  modport slave (
    input  rom_req, rom_addr, icu_rst, icu_i, io_addr, io_valid,
    output rom_ack, rom_data, icu_jmp, icu_rtn, icu_flag_f, icu_rr
  );
endinterface

// File: rtl/mc14500_sequencer.sv
// Program sequencer for the mc14500 ICU: fetch/issue/exec loop with call/return stack.
// Optional breakpoint unit enabled by defining MC14500_SEQ_BREAK_EN.
module mc14500_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  mc14500_sequencer_if.master bus,
  output logic [PC_W-1:0]     pc,
  output logic                halted,
  output logic                stk_err
`ifdef MC14500_SEQ_BREAK_EN
  ,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                bp_en,
  output logic                bp_hit
`endif
);

  localparam int unsigned SP_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W  = SP_W + 1;
  localparam int unsigned DATA_W = 4 + ADDR_W;
  localparam logic [3:0]  OP_SKZ = 4'hE;

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_HALT,
    S_FETCH,
    S_ISSUE,
    S_EXEC
  } state_e;

  state_e            state_q;
  logic              rst_cnt_q;
  logic [PC_W-1:0]   pc_q;
  logic [3:0]        op_q;
  logic [3:0]        icu_i_q;
  logic [ADDR_W-1:0] io_addr_q;
  logic              io_valid_q;
  logic              icu_rst_q;
  logic              rom_req_q;
  logic              halted_q;
  logic              stk_err_q;
  logic              hold_q;
  logic              run_q;
  logic [PC_W-1:0]   stk_q [STACK_DEPTH];
  logic [SP_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [PC_W-1:0]   pc_plus1_c;
  logic [PC_W-1:0]   pc_exec_d;
  logic [SP_W-1:0]   rd_ptr_c;
  logic              push_c;
  logic              pop_c;
  logic              underflow_c;
  logic              nopf_c;
  logic              run_rise_c;
  logic              halt_go_c;
  logic              exec_go_c;
  logic              bp_stop_halt_c;
  logic              bp_stop_exec_c;

  assign rd_ptr_c   = wr_ptr_q - SP_W'(1);
  assign run_rise_c = run & ~run_q;
  // After NOPF or a breakpoint, a held-high run must be re-asserted to resume.
  assign halt_go_c  = run & (~hold_q | run_rise_c);
  assign exec_go_c  = run & ~nopf_c;

  // Control outcome of the instruction in EXEC, in priority order.
  always_comb begin
    pc_plus1_c  = pc_q + PC_W'(1);
    pc_exec_d   = pc_plus1_c;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    underflow_c = 1'b0;
    nopf_c      = 1'b0;
    if (bus.icu_jmp) begin
      push_c    = 1'b1;
      pc_exec_d = PC_W'(io_addr_q);
    end else if (bus.icu_rtn) begin
      if (cnt_q == '0) begin
        underflow_c = 1'b1;
      end else begin
        pop_c     = 1'b1;
        pc_exec_d = stk_q[rd_ptr_c];
      end
    end else if ((op_q == OP_SKZ) && !bus.icu_rr) begin
      pc_exec_d = pc_q + PC_W'(2);
    end else if (bus.icu_flag_f) begin
      nopf_c = 1'b1;
    end
  end

`ifdef MC14500_SEQ_BREAK_EN
  logic bp_hit_q;
  logic bp_skip_q;

  assign bp_stop_halt_c = bp_en & (pc_q == bp_addr) & ~bp_skip_q;
  assign bp_stop_exec_c = bp_en & (pc_exec_d == bp_addr);
  assign bp_hit         = bp_hit_q;

  // bp_skip_q lets the resumed fetch pass the breakpoint it stopped on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else if (((state_q == S_HALT) && halt_go_c && bp_stop_halt_c) ||
                 ((state_q == S_EXEC) && exec_go_c && bp_stop_exec_c)) begin
      bp_hit_q  <= 1'b1;
      bp_skip_q <= 1'b1;
    end else begin
      if (run_rise_c) bp_hit_q <= 1'b0;
      if (state_q == S_FETCH) bp_skip_q <= 1'b0;
    end
  end
`else
  assign bp_stop_halt_c = 1'b0;
  assign bp_stop_exec_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST_HOLD;
      rst_cnt_q  <= 1'b0;
      pc_q       <= '0;
      op_q       <= '0;
      icu_i_q    <= '0;
      io_addr_q  <= '0;
      io_valid_q <= 1'b0;
      icu_rst_q  <= 1'b1;
      rom_req_q  <= 1'b0;
      halted_q   <= 1'b0;
      stk_err_q  <= 1'b0;
      hold_q     <= 1'b0;
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      run_q <= run;
      case (state_q)
        S_RST_HOLD: begin
          rst_cnt_q <= 1'b1;
          if (rst_cnt_q) begin
            icu_rst_q <= 1'b0;
            halted_q  <= 1'b1;
            state_q   <= S_HALT;
          end
        end
        S_HALT: begin
          if (halt_go_c) begin
            if (bp_stop_halt_c) begin
              hold_q <= 1'b1;
            end else begin
              hold_q    <= 1'b0;
              halted_q  <= 1'b0;
              rom_req_q <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.rom_ack) begin
            op_q       <= bus.rom_data[DATA_W-1 -: 4];
            icu_i_q    <= bus.rom_data[DATA_W-1 -: 4];
            io_addr_q  <= bus.rom_data[ADDR_W-1:0];
            io_valid_q <= 1'b1;
            rom_req_q  <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          icu_i_q <= 4'h0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          io_valid_q <= 1'b0;
          pc_q       <= pc_exec_d;
          // Full stack overwrites its oldest entry; the count saturates.
          if (push_c) begin
            stk_q[wr_ptr_q] <= pc_plus1_c;
            wr_ptr_q        <= wr_ptr_q + SP_W'(1);
            if (cnt_q == CNT_W'(STACK_DEPTH)) stk_err_q <= 1'b1;
            else                               cnt_q     <= cnt_q + CNT_W'(1);
          end
          if (pop_c) begin
            wr_ptr_q <= rd_ptr_c;
            cnt_q    <= cnt_q - CNT_W'(1);
          end
          if (underflow_c) stk_err_q <= 1'b1;
          if (exec_go_c && !bp_stop_exec_c) begin
            rom_req_q <= 1'b1;
            state_q   <= S_FETCH;
          end else begin
            halted_q <= 1'b1;
            hold_q   <= nopf_c | bp_stop_exec_c;
            state_q  <= S_HALT;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign bus.rom_req  = rom_req_q;
  assign bus.rom_addr = pc_q;
  assign bus.icu_rst  = icu_rst_q;
  assign bus.icu_i    = icu_i_q;
  assign bus.io_addr  = io_addr_q;
  assign bus.io_valid = io_valid_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign stk_err      = stk_err_q;

endmodule
